// File: rtl/regfile_seq_pkg.sv
// Shared definitions for the register-file operation sequencer: default widths,
// FSM states and ALU opcodes.
package regfile_seq_pkg;

  localparam int DEF_DATA_W = 2;
  localparam int DEF_ADDR_W = 1;
  localparam int DEF_CNT_W  = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    EXEC = 2'd2,
    WB   = 2'd3
  } state_e;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_XOR = 3'b011;
  localparam logic [2:0] OP_LDI = 3'b100;

endpackage

// File: rtl/alu_2op.sv
// Combinational two-operand ALU: ADD, SUB, AND, XOR and load-immediate.
// Opcodes 101-111 fall back to load-immediate.
module alu_2op
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [2:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [DATA_W-1:0] imm,
  output logic [DATA_W-1:0] y,
  output logic              carry,
  output logic              zero
);

  logic [DATA_W:0] sum_s;
  logic [DATA_W:0] diff_s;

  // Widened add/subtract; the extra MSB is carry-out, or borrow (a < b) for subtract.
  always_comb begin
    sum_s  = {1'b0, a} + {1'b0, b};
    diff_s = {1'b0, a} - {1'b0, b};
  end

  // Opcode decode into result and carry/borrow flag.
  always_comb begin
    y     = {DATA_W{1'b0}};
    carry = 1'b0;
    case (op)
      OP_ADD: begin
        y     = sum_s[DATA_W-1:0];
        carry = sum_s[DATA_W];
      end
      OP_SUB: begin
        y     = diff_s[DATA_W-1:0];
        carry = diff_s[DATA_W];
      end
      OP_AND: begin
        y     = a & b;
        carry = 1'b0;
      end
      OP_XOR: begin
        y     = a ^ b;
        carry = 1'b0;
      end
      default: begin
        y     = imm;
        carry = 1'b0;
      end
    endcase
  end

  // Zero flag follows the truncated result.
  always_comb begin
    zero = (y == {DATA_W{1'b0}});
  end

endmodule

// File: rtl/regfile_op_sequencer.sv
// Fixed four-cycle instruction sequencer (IDLE -> READ -> EXEC -> WB) driving a
// register RAM with one write port and two combinational read ports.
module regfile_op_sequencer
  import regfile_seq_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [2:0]        In_Op,
  input  logic [ADDR_W-1:0] In_Rs1,
  input  logic [ADDR_W-1:0] In_Rs2,
  input  logic [ADDR_W-1:0] In_Rd,
  input  logic [DATA_W-1:0] In_Imm,
  input  logic              In_WB,
  output logic [ADDR_W-1:0] Read_Address_1,
  output logic [ADDR_W-1:0] Read_Address_2,
  input  logic [DATA_W-1:0] Read_Data_1,
  input  logic [DATA_W-1:0] Read_Data_2,
  output logic              Write_Enable,
  output logic [ADDR_W-1:0] Write_Address,
  output logic [DATA_W-1:0] Write_Data,
  output logic [DATA_W-1:0] Result,
  output logic              Carry,
  output logic              Zero,
  output logic              Done,
  output logic [CNT_W-1:0]  Op_Count
);

  state_e state_r;
  state_e state_nxt_s;
  logic   accept_s;

  logic              ready_r;
  logic [2:0]        op_r;
  logic [ADDR_W-1:0] rd_r;
  logic [DATA_W-1:0] imm_r;
  logic              wb_r;
  logic [DATA_W-1:0] a_r;
  logic [DATA_W-1:0] b_r;

  logic [ADDR_W-1:0] rd_addr1_r;
  logic [ADDR_W-1:0] rd_addr2_r;
  logic              we_r;
  logic [ADDR_W-1:0] wr_addr_r;
  logic [DATA_W-1:0] wr_data_r;
  logic [DATA_W-1:0] result_r;
  logic              carry_r;
  logic              zero_r;
  logic              done_r;
  logic [CNT_W-1:0]  op_count_r;

  logic [DATA_W-1:0] alu_y_s;
  logic              alu_c_s;
  logic              alu_z_s;

  alu_2op #(
    .DATA_W(DATA_W)
  ) u_alu (
    .op   (op_r),
    .a    (a_r),
    .b    (b_r),
    .imm  (imm_r),
    .y    (alu_y_s),
    .carry(alu_c_s),
    .zero (alu_z_s)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; the walk is fixed with no stalls once an instruction is taken.
  always_comb begin
    state_nxt_s = state_r;
    accept_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (In_Valid && ready_r) begin
          accept_s    = 1'b1;
          state_nxt_s = READ;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      READ:    state_nxt_s = EXEC;
      EXEC:    state_nxt_s = WB;
      WB:      state_nxt_s = IDLE;
      default: state_nxt_s = IDLE;
    endcase
  end

  // Ready is registered from the next state so it is high exactly while in IDLE.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ready_r <= 1'b1;
    end else begin
      ready_r <= (state_nxt_s == IDLE);
    end
  end

  // Instruction latch; read addresses are driven from here so the RAM is addressed during READ.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      op_r       <= 3'b000;
      rd_r       <= {ADDR_W{1'b0}};
      imm_r      <= {DATA_W{1'b0}};
      wb_r       <= 1'b0;
      rd_addr1_r <= {ADDR_W{1'b0}};
      rd_addr2_r <= {ADDR_W{1'b0}};
    end else if (accept_s) begin
      op_r       <= In_Op;
      rd_r       <= In_Rd;
      imm_r      <= In_Imm;
      wb_r       <= In_WB;
      rd_addr1_r <= In_Rs1;
      rd_addr2_r <= In_Rs2;
    end
  end

  // Operand capture at the end of READ, before any writeback can disturb the RAM.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      a_r <= {DATA_W{1'b0}};
      b_r <= {DATA_W{1'b0}};
    end else if (state_r == READ) begin
      a_r <= Read_Data_1;
      b_r <= Read_Data_2;
    end
  end

  // EXEC registers the result and stages the WB-cycle write; WB retires the operation.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      result_r   <= {DATA_W{1'b0}};
      carry_r    <= 1'b0;
      zero_r     <= 1'b0;
      wr_addr_r  <= {ADDR_W{1'b0}};
      wr_data_r  <= {DATA_W{1'b0}};
      we_r       <= 1'b0;
      done_r     <= 1'b0;
      op_count_r <= {CNT_W{1'b0}};
    end else if (state_r == EXEC) begin
      result_r  <= alu_y_s;
      carry_r   <= alu_c_s;
      zero_r    <= alu_z_s;
      wr_addr_r <= rd_r;
      wr_data_r <= alu_y_s;
      we_r      <= wb_r;
      done_r    <= 1'b1;
    end else if (state_r == WB) begin
      we_r       <= 1'b0;
      done_r     <= 1'b0;
      op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign In_Ready       = ready_r;
  assign Read_Address_1 = rd_addr1_r;
  assign Read_Address_2 = rd_addr2_r;
  assign Write_Enable   = we_r;
  assign Write_Address  = wr_addr_r;
  assign Write_Data     = wr_data_r;
  assign Result         = result_r;
  assign Carry          = carry_r;
  assign Zero           = zero_r;
  assign Done           = done_r;
  assign Op_Count       = op_count_r;

endmodule

// File: tb/tb_regfile_op_sequencer.sv
// Bench for regfile_op_sequencer with a 2x2-bit register RAM, a vector table,
// hand-written corner sequences and randomized instructions against a reference model.
module tb_regfile_op_sequencer;

  logic       clk;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_op;
  logic       in_rs1;
  logic       in_rs2;
  logic       in_rd;
  logic [1:0] in_imm;
  logic       in_wb;
  logic       ra1;
  logic       ra2;
  logic [1:0] rd1;
  logic [1:0] rd2;
  logic       we;
  logic       wa;
  logic [1:0] wd;
  logic [1:0] result;
  logic       carry;
  logic       zero;
  logic       done;
  logic [7:0] op_count;

  logic [1:0] ram [0:1];
  int         we_cnt;
  int         n_checks;
  int         n_fail;
  int         m_reg [0:1];
  int         m_cnt;

  regfile_op_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .In_Valid      (in_valid),
    .In_Ready      (in_ready),
    .In_Op         (in_op),
    .In_Rs1        (in_rs1),
    .In_Rs2        (in_rs2),
    .In_Rd         (in_rd),
    .In_Imm        (in_imm),
    .In_WB         (in_wb),
    .Read_Address_1(ra1),
    .Read_Address_2(ra2),
    .Read_Data_1   (rd1),
    .Read_Data_2   (rd2),
    .Write_Enable  (we),
    .Write_Address (wa),
    .Write_Data    (wd),
    .Result        (result),
    .Carry         (carry),
    .Zero          (zero),
    .Done          (done),
    .Op_Count      (op_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register RAM: write at the clock edge, combinational reads, cleared by reset.
  always @(posedge clk or posedge reset) begin
    if (reset) begin
      ram[0] <= 2'b00;
      ram[1] <= 2'b00;
    end else if (we) begin
      ram[wa] <= wd;
    end
  end
  assign rd1 = ram[ra1];
  assign rd2 = ram[ra2];

  initial we_cnt = 0;
  always @(posedge clk) if (we) we_cnt = we_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: plain arithmetic on the architectural registers.
  task automatic model_op(input int op, input int rs1, input int rs2, input int imm,
                          output int y, output int c, output int z);
    int a;
    int b;
    a = m_reg[rs1];
    b = m_reg[rs2];
    case (op)
      0:       begin y = (a + b) % 4;     c = ((a + b) > 3) ? 1 : 0; end
      1:       begin y = (a - b + 4) % 4; c = (a < b) ? 1 : 0;       end
      2:       begin y = a & b;           c = 0;                      end
      3:       begin y = a ^ b;           c = 0;                      end
      default: begin y = imm;             c = 0;                      end
    endcase
    z = (y == 0) ? 1 : 0;
  endtask

  task automatic model_commit(input int rd, input int wb, input int y);
    if (wb != 0) m_reg[rd] = y;
    m_cnt = (m_cnt + 1) % 256;
  endtask

  task automatic model_reset();
    m_reg[0] = 0;
    m_reg[1] = 0;
    m_cnt    = 0;
  endtask

  task automatic drive(input int op, input int rs1, input int rs2, input int rd,
                       input int imm, input int wb);
    in_op  = op[2:0];
    in_rs1 = rs1[0];
    in_rs2 = rs2[0];
    in_rd  = rd[0];
    in_imm = imm[1:0];
    in_wb  = wb[0];
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_ready"},  in_ready, 1);
    check({tag, "_done"},   done, 0);
    check({tag, "_we"},     we, 0);
    check({tag, "_wa"},     wa, 0);
    check({tag, "_wd"},     wd, 0);
    check({tag, "_ra1"},    ra1, 0);
    check({tag, "_ra2"},    ra2, 0);
    check({tag, "_result"}, result, 0);
    check({tag, "_carry"},  carry, 0);
    check({tag, "_zero"},   zero, 0);
    check({tag, "_count"},  op_count, 0);
  endtask

  // One complete instruction with cycle-by-cycle checks, then model update.
  task automatic issue(input int op, input int rs1, input int rs2, input int rd,
                       input int imm, input int wb);
    int y;
    int c;
    int z;
    int t;
    model_op(op, rs1, rs2, imm, y, c, z);
    @(negedge clk);
    drive(op, rs1, rs2, rd, imm, wb);
    in_valid = 1'b1;
    t = 0;
    while (!in_ready && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("accept_wait", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    drive($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
          $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
    check("read_ready", in_ready, 0);
    check("read_done", done, 0);
    check("read_ra1", ra1, rs1);
    check("read_ra2", ra2, rs2);
    @(negedge clk);
    check("exec_done", done, 0);
    check("exec_we", we, 0);
    @(negedge clk);
    check("wb_done", done, 1);
    check("wb_we", we, wb);
    check("wb_wa", wa, rd);
    check("wb_wd", wd, y);
    check("wb_result", result, y);
    check("wb_carry", carry, c);
    check("wb_zero", zero, z);
    check("wb_ready", in_ready, 0);
    @(negedge clk);
    model_commit(rd, wb, y);
    check("idle_done", done, 0);
    check("idle_we", we, 0);
    check("idle_ready", in_ready, 1);
    check("idle_result", result, y);
    check("op_count", op_count, m_cnt);
    check("ram_r0", ram[0], m_reg[0]);
    check("ram_r1", ram[1], m_reg[1]);
  endtask

  typedef struct {
    int op; int rs1; int rs2; int rd; int imm; int wb;
    int exp_y; int exp_c; int exp_z; int exp_r0; int exp_r1; int exp_cnt;
  } vec_t;

  vec_t vecs [5];

  initial begin
    int acc [$];
    int busy_low;
    int sw;
    int we0;
    int y;
    int c;
    int z;
    int ya;
    int ca;
    int za;
    n_checks = 0;
    n_fail   = 0;
    model_reset();

    vecs[0] = '{4, 0, 0, 0, 1, 1,  1, 0, 0,  1, 0, 1};
    vecs[1] = '{4, 0, 0, 1, 3, 1,  3, 0, 0,  1, 3, 2};
    vecs[2] = '{0, 0, 1, 0, 0, 1,  0, 1, 1,  0, 3, 3};
    vecs[3] = '{1, 1, 0, 1, 0, 1,  3, 0, 0,  0, 3, 4};
    vecs[4] = '{3, 1, 1, 1, 0, 0,  0, 0, 1,  0, 3, 5};

    in_valid = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    reset = 1'b1;
    #7;
    check_reset_state("por");
    @(negedge clk);
    reset = 1'b0;

    // Reset pulse mid-cycle while an LDI is in READ.
    @(negedge clk);
    drive(4, 1, 1, 1, 2, 1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("pre_rst_ra1", ra1, 1);
    #2 reset = 1'b1;
    #1;
    check_reset_state("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("mid_rst_ram1", ram[1], 0);
    check("mid_rst_count", op_count, 0);
    model_reset();

    // Directed table: LDI, LDI, ADD, SUB, XOR without writeback.
    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].op, vecs[i].rs1, vecs[i].rs2, vecs[i].rd, vecs[i].imm, vecs[i].wb);
      check("tbl_result", result, vecs[i].exp_y);
      check("tbl_carry", carry, vecs[i].exp_c);
      check("tbl_zero", zero, vecs[i].exp_z);
      check("tbl_r0", ram[0], vecs[i].exp_r0);
      check("tbl_r1", ram[1], vecs[i].exp_r1);
      check("tbl_count", op_count, vecs[i].exp_cnt);
    end

    // In_Valid held high across two instructions: LDI r0,2 then ADD r1=r0+r0.
    acc.delete();
    busy_low = 0;
    sw = 0;
    @(negedge clk);
    drive(4, 0, 0, 0, 2, 1);
    in_valid = 1'b1;
    for (int cy = 0; cy < 14; cy++) begin
      if (in_valid && in_ready) acc.push_back(cy);
      else if (in_valid) busy_low++;
      @(negedge clk);
      if (acc.size() == 1 && sw == 0) begin
        drive(0, 0, 0, 1, 1, 1);
        sw = 1;
      end
      if (acc.size() == 2 && sw == 1) begin
        in_valid = 1'b0;
        sw = 2;
      end
    end
    check("hold_accepts", acc.size(), 2);
    check("hold_spacing", (acc.size() >= 2) ? (acc[1] - acc[0]) : -1, 4);
    check("hold_busy_low", busy_low, 3);
    model_op(4, 0, 0, 2, ya, ca, za);
    model_commit(0, 1, ya);
    model_op(0, 0, 0, 1, y, c, z);
    model_commit(1, 1, y);
    check("hold_result", result, y);
    check("hold_carry", carry, c);
    check("hold_r0", ram[0], m_reg[0]);
    check("hold_r1", ram[1], m_reg[1]);
    check("hold_count", op_count, m_cnt);

    // Reset during EXEC of ADD r0 = r1 + r1.
    @(negedge clk);
    drive(0, 1, 1, 0, 0, 1);
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    we0 = we_cnt;
    #2 reset = 1'b1;
    #1;
    check_reset_state("exec_rst");
    @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    check("exec_rst_we_pulses", we_cnt - we0, 0);
    check("exec_rst_ram0", ram[0], 0);
    check("exec_rst_ram1", ram[1], 0);
    check("exec_rst_ready", in_ready, 1);
    check("exec_rst_count", op_count, 0);
    model_reset();

    // Randomized instruction stream against the model.
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clk);
      issue($urandom_range(0, 7), $urandom_range(0, 1), $urandom_range(0, 1),
            $urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 1));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
